// File: rtl/conv1_ctrl_if.sv
// conv1_ctrl_if: handshake and result bus between the pixel source,
// the conv1 sequencer and the conv1 datapath.
interface conv1_ctrl_if #(
  parameter int WIDTH  = 28,
  parameter int HEIGHT = 36,
  parameter int NGRP   = 4
);
  localparam int GW = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH);

  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          buf_shift;
  logic          calc_en;
  logic [GW-1:0] calc_grp;
  logic          out_valid;
  logic [GW-1:0] out_grp;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          busy;
  logic          done;

  modport master (
    output start, in_valid,
    input  in_ready, buf_shift, calc_en, calc_grp,
    input  out_valid, out_grp, out_row, out_col,
    input  busy, done
  );

  modport slave (
    input  start, in_valid,
    output in_ready, buf_shift, calc_en, calc_grp,
    output out_valid, out_grp, out_row, out_col,
    output busy, done
  );
endinterface

// File: rtl/conv1_ctrl.sv
// conv1_ctrl: first conv layer sequencer on a single clock.
// Feeds the line buffer and time-multiplexes channel groups.
module conv1_ctrl #(
  parameter int WIDTH    = 28,
  parameter int HEIGHT   = 36,
  parameter int KSIZE    = 3,
  parameter int OUT_CH   = 32,
  parameter int PAR      = 8,
  parameter int CALC_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  conv1_ctrl_if.slave bus
);
  localparam int NGRP = OUT_CH / PAR;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int RW   = $clog2(HEIGHT);
  localparam int CW   = $clog2(WIDTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FEED  = 3'd1;
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CALC_LAT-1:0] OLD_M =
    CALC_LAT'(1) << (CALC_LAT - 1);

  logic [2:0]    state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [RW-1:0] prow_q, prow_d;
  logic [CW-1:0] pcol_q, pcol_d;
  logic          last_q, last_d;

  logic [CALC_LAT-1:0]         vld_q;
  logic [CALC_LAT-1:0][GW-1:0] dgrp_q;
  logic [CALC_LAT-1:0][RW-1:0] drow_q;
  logic [CALC_LAT-1:0][CW-1:0] dcol_q;

  logic accept;
  logic interior;
  logic col_last;
  logic row_last;
  logic grp_last;
  logic early_empty;

  assign accept   = (state_q == S_FEED) && bus.in_valid;
  assign interior = (row_q >= RW'(KSIZE - 1)) &&
                    (col_q >= CW'(KSIZE - 1));
  assign col_last = (col_q == CW'(WIDTH - 1));
  assign row_last = (row_q == RW'(HEIGHT - 1));
  assign grp_last = (grp_q == GW'(NGRP - 1));

  // only the oldest stage may still hold a result
  assign early_empty = (vld_q & ~OLD_M) == '0;

  assign bus.in_ready  = (state_q == S_FEED);
  assign bus.buf_shift = accept;
  assign bus.calc_en   = (state_q == S_CALC);
  assign bus.calc_grp  = grp_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.out_valid = vld_q[CALC_LAT-1];
  assign bus.out_grp   = dgrp_q[CALC_LAT-1];
  assign bus.out_row   = drow_q[CALC_LAT-1];
  assign bus.out_col   = dcol_q[CALC_LAT-1];

  // next-state: pixel position tracking and group sequencing
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    grp_d   = grp_q;
    prow_d  = prow_q;
    pcol_d  = pcol_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FEED;
          row_d   = '0;
          col_d   = '0;
          grp_d   = '0;
        end
      end
      S_FEED: begin
        if (bus.in_valid) begin
          if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          if (interior) begin
            state_d = S_CALC;
            grp_d   = '0;
            prow_d  = row_q - RW'(KSIZE - 1);
            pcol_d  = col_q - CW'(KSIZE - 1);
            last_d  = row_last && col_last;
          end
        end
      end
      S_CALC: begin
        if (grp_last) begin
          grp_d   = '0;
          state_d = last_q ? S_DRAIN : S_FEED;
        end else begin
          grp_d = grp_q + GW'(1);
        end
      end
      S_DRAIN: begin
        if (bus.out_valid && early_empty) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // controller state and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      grp_q   <= '0;
      prow_q  <= '0;
      pcol_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      grp_q   <= grp_d;
      prow_q  <= prow_d;
      pcol_q  <= pcol_d;
      last_q  <= last_d;
    end
  end

  // result tag delay line matching the datapath latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      dgrp_q <= '0;
      drow_q <= '0;
      dcol_q <= '0;
    end else begin
      vld_q[0]  <= (state_q == S_CALC);
      dgrp_q[0] <= grp_q;
      drow_q[0] <= prow_q;
      dcol_q[0] <= pcol_q;
      for (int i = 1; i < CALC_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        dgrp_q[i] <= dgrp_q[i-1];
        drow_q[i] <= drow_q[i-1];
        dcol_q[i] <= dcol_q[i-1];
      end
    end
  end
endmodule

// File: tb/tb_conv1_ctrl.sv
// tb_conv1_ctrl: random-stimulus scoreboard bench for conv1_ctrl.
// Expected results come from raster pixel order in a queue model.
module tb_conv1_ctrl;
  localparam int W   = 28;
  localparam int H   = 36;
  localparam int K   = 3;
  localparam int OC  = 32;
  localparam int P   = 8;
  localparam int LAT = 3;
  localparam int NG  = OC / P;
  localparam int NRES = (W - K + 1) * (H - K + 1) * NG;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv1_ctrl_if #(.WIDTH(W), .HEIGHT(H), .NGRP(NG)) bus ();
  conv1_ctrl_if #(.WIDTH(4), .HEIGHT(4), .NGRP(1)) sbus ();

  conv1_ctrl #(
    .WIDTH(W), .HEIGHT(H), .KSIZE(K),
    .OUT_CH(OC), .PAR(P), .CALC_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  conv1_ctrl #(
    .WIDTH(4), .HEIGHT(4), .KSIZE(3),
    .OUT_CH(8), .PAR(8), .CALC_LAT(3)
  ) sdut (
    .clk(clk), .rst_n(rst_n), .bus(sbus)
  );

  typedef struct {int g; int r; int c;} res_t;
  typedef struct {int cy; int g;} cal_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  res_t res_q[$];
  cal_t cal_q[$];
  int   lat_q[$];
  res_t re;
  res_t last_res;
  cal_t ce;
  int   lc;
  int   shifts, calcs, outs, dones;
  int   last_out_cyc = -10;
  bit   done_prev = 1'b0;

  int s_pos[$];
  int s_last_calc = -1;
  int s_done = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string nm,
                       input int act, input int exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic int outvec();
    return int'({bus.in_ready, bus.buf_shift, bus.calc_en,
                 bus.calc_grp, bus.out_valid, bus.out_grp,
                 bus.out_row, bus.out_col, bus.busy, bus.done});
  endfunction

  // monitor: pops expectations whenever the DUT presents activity
  always @(negedge clk) begin
    if (rst_n) begin
      if (done_prev)
        check(!bus.busy, "busy_after_done", int'(bus.busy), 0);
      done_prev = bus.done;
      if (bus.buf_shift) begin
        shifts++;
        check(bus.in_valid && bus.in_ready, "shift_hs",
              int'(bus.in_ready), 1);
      end
      if (bus.calc_en) begin
        calcs++;
        check(!bus.in_ready, "ready_in_calc", int'(bus.in_ready), 0);
        if (cal_q.size() == 0) begin
          check(1'b0, "calc_unexpected", cyc, -1);
        end else begin
          ce = cal_q.pop_front();
          check(cyc == ce.cy, "calc_cycle", cyc, ce.cy);
          check(int'(bus.calc_grp) == ce.g, "calc_grp",
                int'(bus.calc_grp), ce.g);
        end
        lat_q.push_back(cyc);
      end
      if (bus.out_valid) begin
        outs++;
        if (res_q.size() == 0) begin
          check(1'b0, "result_unexpected", cyc, -1);
        end else begin
          re = res_q.pop_front();
          check(int'(bus.out_grp) == re.g, "out_grp",
                int'(bus.out_grp), re.g);
          check(int'(bus.out_row) == re.r, "out_row",
                int'(bus.out_row), re.r);
          check(int'(bus.out_col) == re.c, "out_col",
                int'(bus.out_col), re.c);
        end
        if (lat_q.size() != 0) begin
          lc = lat_q.pop_front();
          check(cyc - lc == LAT, "latency", cyc - lc, LAT);
        end
        last_out_cyc = cyc;
        last_res = '{int'(bus.out_grp), int'(bus.out_row),
                     int'(bus.out_col)};
      end
      if (bus.done) begin
        dones++;
        check(cyc == last_out_cyc + 1, "done_timing",
              cyc, last_out_cyc + 1);
        check(res_q.size() == 0, "results_pending", res_q.size(), 0);
      end
    end else begin
      done_prev = 1'b0;
    end
  end

  // small-configuration monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (sbus.out_valid)
        s_pos.push_back(int'(sbus.out_row) * 16 + int'(sbus.out_col));
      if (sbus.calc_en) s_last_calc = cyc;
      if (sbus.done) s_done = cyc;
    end
  end

  task automatic clear_counts();
    shifts = 0;
    calcs  = 0;
    outs   = 0;
    dones  = 0;
  endtask

  // driver: feeds one frame; pushes expectations on each accept
  task automatic feed(input bit bp, input int spur, input int abort_px);
    int n;
    int r;
    int c;
    bus.start = 1'b1;
    for (int k = 0; k < W * H; k++) begin
      if (bp) begin
        while ($urandom_range(1, 0) == 0) begin
          bus.in_valid = 1'b0;
          @(posedge clk); #1;
          bus.start = 1'b0;
        end
      end
      if (k == spur) bus.start = 1'b1;
      bus.in_valid = 1'b1;
      n = 0;
      forever begin
        @(negedge clk);
        if (bus.in_ready) break;
        n++;
        if (n > 50) begin
          check(1'b0, "accept_timeout", k, -1);
          bus.in_valid = 1'b0;
          bus.start = 1'b0;
          return;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      r = k / W;
      c = k % W;
      if (r >= K - 1 && c >= K - 1) begin
        for (int g = 0; g < NG; g++) begin
          res_q.push_back('{g, r - K + 1, c - K + 1});
          cal_q.push_back('{cyc + 1 + g, g});
        end
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (k == abort_px) begin
        bus.in_valid = 1'b0;
        n = 0;
        forever begin
          @(negedge clk);
          if (bus.calc_en && bus.calc_grp == 2) break;
          n++;
          if (n > 20) break;
        end
        check(n <= 20, "abort_reach_grp2", n, 0);
        #2 rst_n = 1'b0;
        #1 check(outvec() == 0, "reset_midframe_outputs", outvec(), 0);
        res_q.delete();
        cal_q.delete();
        lat_q.delete();
        return;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic frame_end(input string tag);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.done) break;
      n++;
      if (n > 400) break;
    end
    check(n <= 400, {tag, "_done_timeout"}, n, 400);
    @(negedge clk);
    check(outs == NRES, {tag, "_results"}, outs, NRES);
    check(shifts == W * H, {tag, "_shifts"}, shifts, W * H);
    check(dones == 1, {tag, "_done_count"}, dones, 1);
    check(!bus.busy, {tag, "_busy_end"}, int'(bus.busy), 0);
    check(last_res.r == H - K, {tag, "_last_row"}, last_res.r, H - K);
    check(last_res.c == W - K, {tag, "_last_col"}, last_res.c, W - K);
    check(last_res.g == NG - 1, {tag, "_last_grp"}, last_res.g, NG - 1);
    check(cal_q.size() == 0, {tag, "_calc_pending"}, cal_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got 1, want 0");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit ok;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    sbus.start = 1'b0;
    sbus.in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check(outvec() == 0, "reset_outputs", outvec(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    clear_counts();
    for (int i = 0; i < 100; i++) begin
      bus.in_valid = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check(shifts == 0, "idle_shift", shifts, 0);
    check(calcs == 0, "idle_calc", calcs, 0);
    check(!bus.busy, "idle_busy", int'(bus.busy), 0);

    clear_counts();
    feed(1'b0, -1, -1);
    frame_end("cont");

    clear_counts();
    feed(1'b1, 500, -1);
    frame_end("bp");

    clear_counts();
    feed(1'b0, -1, 300);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid || bus.calc_en || bus.busy || bus.done)
        ok = 1'b0;
    end
    check(ok, "reset_discard", int'(!ok), 0);
    check(dones == 0, "reset_no_done", dones, 0);
    @(posedge clk); #1;

    clear_counts();
    feed(1'b0, -1, -1);
    frame_end("after_reset");

    s_pos.delete();
    sbus.start = 1'b1;
    sbus.in_valid = 1'b1;
    @(posedge clk); #1;
    sbus.start = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (sbus.done) break;
      n++;
      if (n > 200) break;
    end
    check(n <= 200, "small_done_timeout", n, 200);
    @(posedge clk); #1;
    sbus.in_valid = 1'b0;
    check(s_pos.size() == 4, "small_count", s_pos.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < s_pos.size())
        check(s_pos[i] == (i / 2) * 16 + (i % 2), "small_pos",
              s_pos[i], (i / 2) * 16 + (i % 2));
    end
    check(s_done - s_last_calc == 4, "small_done_lat",
          s_done - s_last_calc, 4);
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/conv1_ctrl.md
Name: conv1_ctrl

Overview:
- Sequencer for the first convolution layer. It replaces the divided pixel clock with single-clock enables.
- Accepts the input pixel stream with a valid/ready handshake and tracks row and column.
- Drives the line-buffer shift enable and time-multiplexes the output-channel groups through the shared 3x3 MAC datapath.
- Sits between the pixel source and the conv1 line buffer / calculation units; everything runs on clk.

Parameters:
- WIDTH, 28, pixels per input row
- HEIGHT, 36, input rows per frame
- KSIZE, 3, square kernel size
- OUT_CH, 32, total output channels
- PAR, 8, output channels computed in parallel per calc cycle; OUT_CH must be a multiple of PAR
- CALC_LAT, 3, cycles from calc_en to result valid in the datapath
- Derived: NGRP = OUT_CH/PAR

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame
- in_valid  in  1  input pixel valid
- in_ready  out  1  controller can accept a pixel
- buf_shift  out  1  line-buffer shift enable; equals in_valid & in_ready
- calc_en  out  1  datapath computes the current window for group calc_grp
- calc_grp  out  clog2(NGRP) (min 1)  channel group index for weight select
- out_valid  out  1  result for out_grp/out_row/out_col is present on datapath outputs
- out_grp  out  clog2(NGRP) (min 1)  group of the present result
- out_row  out  clog2(HEIGHT)  output row (0..HEIGHT-KSIZE)
- out_col  out  clog2(WIDTH)  output column (0..WIDTH-KSIZE)
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the last result of the frame

Behaviour:
- Reset (async): state IDLE. All outputs 0; row/col/group counters 0; result delay line cleared.
- FSM states: IDLE, FEED, CALC, DRAIN, DONE.
- IDLE:
  - start=1 -> FEED; busy goes 1 next cycle.
  - start is ignored in every other state.
- FEED:
  - in_ready=1. An accept occurs when in_valid=1; the pixel position is (row, col).
  - Col counter wraps WIDTH-1 -> 0 and increments row.
  - After an accept where row>=KSIZE-1 and col>=KSIZE-1 -> CALC; the window is captured for that position.
  - Otherwise stay in FEED.
  - in_valid=0 produces no state change (stall).
- CALC:
  - in_ready=0; calc_en=1 for exactly NGRP consecutive cycles, with calc_grp = 0..NGRP-1.
  - The first calc cycle immediately follows the accept cycle.
  - The output position latched for this window is (row-KSIZE+1, col-KSIZE+1).
  - After the last group: if the accepted pixel was (HEIGHT-1, WIDTH-1) -> DRAIN, else -> FEED.
- Result pipeline: out_valid/out_grp/out_row/out_col equal calc_en/calc_grp/position delayed by exactly CALC_LAT cycles through a shift register. The register keeps running in every state except reset.
- DRAIN: wait until the final result's out_valid has been asserted, then -> DONE.
- DONE: done=1 for one cycle; busy=0 from the next cycle; -> IDLE.
- Throughput:
  - Border pixels (row<KSIZE-1 or col<KSIZE-1) take 1 cycle each.
  - Interior pixels take 1+NGRP cycles.
  - Total results per frame = (WIDTH-KSIZE+1)*(HEIGHT-KSIZE+1)*NGRP.
- Counters are sized from the parameters; no arithmetic overflow is permitted at the defaults.
- in_valid while in_ready=0: the pixel is not consumed and the source must hold it; buf_shift stays 0.
- Reset mid-frame: everything returns to its reset values immediately, with no done pulse. Pending results in the delay line are discarded (out_valid=0).
- start and in_valid together in IDLE: only start is taken; the pixel is accepted next cycle in FEED.

Test Plan:
- Reset then idle: all outputs 0, in_ready=0; start never pulsed -> no buf_shift or calc_en for 100 cycles.
- Defaults, continuous in_valid=1:
  - First calc_en 1 cycle after accepting pixel 58 (row 2, col 2).
  - calc_grp runs 0,1,2,3, and out_valid for grp 0 appears 3 cycles after its calc_en, with out_row=0, out_col=0.
- Full default frame:
  - Exactly 3536 out_valid pulses (884 positions x 4 groups) and 1008 buf_shift pulses.
  - Last result has out_row=33, out_col=25, out_grp=3; done pulses once, then busy=0.
- Backpressure: toggle in_valid randomly at 50% -> same result sequence as the continuous run; no buf_shift while in_ready=0; no accept during CALC.
- WIDTH=4, HEIGHT=4, OUT_CH=8, PAR=8: 4 results with positions (0,0),(0,1),(1,0),(1,1); done 4 cycles after the final calc_en (CALC_LAT + 1).
- Assert rst_n low mid-CALC at group 2: all outputs 0 immediately; then a new start runs a complete frame correctly; a start pulsed while busy is ignored.
